// File: rtl/operand_dispatcher.sv
// rtl/operand_dispatcher.sv - operand network transmit queue and req/ack sender
module operand_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 7,
  parameter int TIMEOUT = 15
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_result_valid,
  output logic               o_result_ready,
  input  logic [DATA_W-1:0]  i_result_data,
  input  logic               i_result_null,
  input  logic               i_t0_valid,
  input  logic [INSTR_W-1:0] i_t0_instr,
  input  logic [1:0]         i_t0_slot,
  input  logic               i_t1_valid,
  input  logic [INSTR_W-1:0] i_t1_instr,
  input  logic [1:0]         i_t1_slot,
  output logic               o_req_out,
  input  logic               i_ack_in,
  output logic [DATA_W-1:0]  o_operand_data_out,
  output logic               o_operand_null_out,
  output logic [INSTR_W-1:0] o_dest_instr_out,
  output logic [1:0]         o_dest_slot_out,
  output logic               o_busy,
  output logic               o_timeout_err,
  output logic               o_bad_slot_err,
  output logic [15:0]        o_sent_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  // Result queue storage; only entries with at least one usable target are written
  logic [DATA_W-1:0]  r_q_data [DEPTH];
  logic               r_q_null [DEPTH];
  logic               r_q_t0v  [DEPTH];
  logic [INSTR_W-1:0] r_q_t0i  [DEPTH];
  logic [1:0]         r_q_t0s  [DEPTH];
  logic               r_q_t1v  [DEPTH];
  logic [INSTR_W-1:0] r_q_t1i  [DEPTH];
  logic [1:0]         r_q_t1s  [DEPTH];

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  state_t             r_state;
  state_t             w_state_nxt;

  logic               r_req;
  logic [DATA_W-1:0]  r_data;
  logic               r_null;
  logic [INSTR_W-1:0] r_instr;
  logic [1:0]         r_slot;
  logic               r_sel;
  logic [WAIT_W-1:0]  r_wait;
  logic [15:0]        r_sent;
  logic               r_tmo_err;
  logic               r_bad_err;

  logic               w_full;
  logic               w_accept;
  logic               w_t0_ok;
  logic               w_t1_ok;
  logic               w_push;
  logic               w_bad;
  logic [PTR_W-1:0]   w_rd_ptr_inc;
  logic               w_h_t0v;
  logic               w_h_t1v;
  logic               w_n_t0v;

  logic               w_load;
  logic               w_ld_sel;
  logic [PTR_W-1:0]   w_ld_idx;
  logic               w_pop;
  logic               w_ack_ok;
  logic               w_tmo;
  logic [DATA_W-1:0]  w_ld_data;
  logic               w_ld_null;
  logic [INSTR_W-1:0] w_ld_instr;
  logic [1:0]         w_ld_slot;

  // Ready looks only at registered occupancy, so a pop never frees a slot in the same cycle
  assign w_full         = (r_count == CNT_W'(DEPTH));
  assign o_result_ready = !w_full;
  assign w_accept       = i_result_valid && o_result_ready && !i_flush;
  assign w_t0_ok        = i_t0_valid && (i_t0_slot != 2'd3);
  assign w_t1_ok        = i_t1_valid && (i_t1_slot != 2'd3);
  assign w_push         = w_accept && (w_t0_ok || w_t1_ok);
  assign w_bad          = w_accept && ((i_t0_valid && (i_t0_slot == 2'd3)) ||
                                       (i_t1_valid && (i_t1_slot == 2'd3)));

  assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);
  assign w_h_t0v      = r_q_t0v[r_rd_ptr];
  assign w_h_t1v      = r_q_t1v[r_rd_ptr];
  assign w_n_t0v      = r_q_t0v[w_rd_ptr_inc];

  assign w_ld_data  = r_q_data[w_ld_idx];
  assign w_ld_null  = r_q_null[w_ld_idx];
  assign w_ld_instr = w_ld_sel ? r_q_t1i[w_ld_idx] : r_q_t0i[w_ld_idx];
  assign w_ld_slot  = w_ld_sel ? r_q_t1s[w_ld_idx] : r_q_t0s[w_ld_idx];

  // Write accepted entries with invalid-slot targets already masked off
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_data[r_wr_ptr] <= i_result_data;
      r_q_null[r_wr_ptr] <= i_result_null;
      r_q_t0v[r_wr_ptr]  <= w_t0_ok;
      r_q_t0i[r_wr_ptr]  <= i_t0_instr;
      r_q_t0s[r_wr_ptr]  <= i_t0_slot;
      r_q_t1v[r_wr_ptr]  <= w_t1_ok;
      r_q_t1i[r_wr_ptr]  <= i_t1_instr;
      r_q_t1s[r_wr_ptr]  <= i_t1_slot;
    end
  end

  // Queue pointers and occupancy; flush empties the queue outright
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Sender state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Sender next state: pick the target to load, detect ack/timeout, decide when to pop
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ld_sel    = 1'b0;
    w_ld_idx    = r_rd_ptr;
    w_pop       = 1'b0;
    w_ack_ok    = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_load      = 1'b1;
          w_ld_sel    = !w_h_t0v;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (i_ack_in) begin
          w_ack_ok    = 1'b1;
          w_state_nxt = S_GAP;
        end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (!r_sel && w_h_t1v) begin
          w_load      = 1'b1;
          w_ld_sel    = 1'b1;
          w_state_nxt = S_SEND;
        end else begin
          w_pop = 1'b1;
          if (r_count > CNT_W'(1)) begin
            w_load      = 1'b1;
            w_ld_idx    = w_rd_ptr_inc;
            w_ld_sel    = !w_n_t0v;
            w_state_nxt = S_SEND;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_flush) begin
      w_state_nxt = S_IDLE;
      w_load      = 1'b0;
      w_pop       = 1'b0;
      w_ack_ok    = 1'b0;
      w_tmo       = 1'b0;
    end
  end

  // Registered network outputs, wait counter and sticky status
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_req     <= 1'b0;
      r_data    <= '0;
      r_null    <= 1'b0;
      r_instr   <= '0;
      r_slot    <= '0;
      r_sel     <= 1'b0;
      r_wait    <= '0;
      r_sent    <= '0;
      r_tmo_err <= 1'b0;
      r_bad_err <= 1'b0;
    end else begin
      if (i_flush) begin
        r_req <= 1'b0;
      end else if (w_load) begin
        r_req   <= 1'b1;
        r_data  <= w_ld_data;
        r_null  <= w_ld_null;
        r_instr <= w_ld_instr;
        r_slot  <= w_ld_slot;
        r_sel   <= w_ld_sel;
        r_wait  <= '0;
      end else if (w_ack_ok || w_tmo) begin
        r_req <= 1'b0;
      end else if (r_state == S_SEND) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
      if (w_ack_ok) r_sent    <= r_sent + 16'd1;
      if (w_tmo)    r_tmo_err <= 1'b1;
      if (w_bad)    r_bad_err <= 1'b1;
    end
  end

  assign o_req_out          = r_req;
  assign o_operand_data_out = r_data;
  assign o_operand_null_out = r_null;
  assign o_dest_instr_out   = r_instr;
  assign o_dest_slot_out    = r_slot;
  assign o_busy             = (r_count != '0) || (r_state != S_IDLE);
  assign o_timeout_err      = r_tmo_err;
  assign o_bad_slot_err     = r_bad_err;
  assign o_sent_count       = r_sent;

endmodule

// File: tb/tb_operand_dispatcher.sv
// tb/tb_operand_dispatcher.sv - randomized and directed check of operand_dispatcher against a target-list model
module tb_operand_dispatcher;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        rv = 1'b0;
  logic        rr;
  logic [63:0] rdata = '0;
  logic        rnull = 1'b0;
  logic        t0v = 1'b0;
  logic [6:0]  t0i = '0;
  logic [1:0]  t0s = '0;
  logic        t1v = 1'b0;
  logic [6:0]  t1i = '0;
  logic [1:0]  t1s = '0;
  logic        req;
  logic        ack = 1'b0;
  logic [63:0] odata;
  logic        onull;
  logic [6:0]  oinstr;
  logic [1:0]  oslot;
  logic        busy;
  logic        terr;
  logic        berr;
  logic [15:0] scnt;

  operand_dispatcher #(.DEPTH(DEPTH), .DATA_W(64), .INSTR_W(7), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_result_valid(rv), .o_result_ready(rr),
    .i_result_data(rdata), .i_result_null(rnull),
    .i_t0_valid(t0v), .i_t0_instr(t0i), .i_t0_slot(t0s),
    .i_t1_valid(t1v), .i_t1_instr(t1i), .i_t1_slot(t1s),
    .o_req_out(req), .i_ack_in(ack),
    .o_operand_data_out(odata), .o_operand_null_out(onull),
    .o_dest_instr_out(oinstr), .o_dest_slot_out(oslot),
    .o_busy(busy), .o_timeout_err(terr), .o_bad_slot_err(berr),
    .o_sent_count(scnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted result becomes a list of usable targets sent in order
  typedef struct packed {
    logic [63:0] d;
    logic        n;
    logic [1:0]  nt;
    logic [6:0]  i0;
    logic [1:0]  s0;
    logic [6:0]  i1;
    logic [1:0]  s1;
  } ent_t;

  ent_t        m_q[$];
  ent_t        m_e;
  bit          m_acc;
  int          m_idx = 0;
  bit          m_req = 0;
  bit          m_pop = 0;
  int          m_hi = 0;
  logic [15:0] m_sent = '0;
  bit          m_tmo = 0;
  bit          m_bad = 0;
  logic [63:0] m_data = '0;
  logic        m_null = 1'b0;
  logic [6:0]  m_instr = '0;
  logic [1:0]  m_slot = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_req = 0; m_idx = 0; m_pop = 0; m_hi = 0;
      m_sent = '0; m_tmo = 0; m_bad = 0;
    end else if (flush) begin
      m_q.delete();
      m_req = 0; m_idx = 0; m_pop = 0;
    end else begin
      m_acc = rv && (m_q.size() < DEPTH);
      m_e = '0;
      m_e.d = rdata;
      m_e.n = rnull;
      if (t0v && t0s != 2'd3) begin
        m_e.i0 = t0i; m_e.s0 = t0s; m_e.nt = 2'd1;
      end
      if (t1v && t1s != 2'd3) begin
        if (m_e.nt == 0) begin m_e.i0 = t1i; m_e.s0 = t1s; end
        else begin m_e.i1 = t1i; m_e.s1 = t1s; end
        m_e.nt = m_e.nt + 2'd1;
      end
      if (m_acc && ((t0v && t0s == 2'd3) || (t1v && t1s == 2'd3))) m_bad = 1;
      if (m_req) begin
        m_hi++;
        if (ack || m_hi == TIMEOUT) begin
          if (ack) m_sent = m_sent + 16'd1;
          else     m_tmo = 1;
          m_req = 0;
          m_idx++;
          if (m_idx == int'(m_q[0].nt)) m_pop = 1;
        end
      end else begin
        if (m_pop) begin
          void'(m_q.pop_front());
          m_idx = 0;
          m_pop = 0;
        end
        if (m_q.size() > 0) begin
          m_req   = 1;
          m_hi    = 0;
          m_data  = m_q[0].d;
          m_null  = m_q[0].n;
          m_instr = (m_idx == 0) ? m_q[0].i0 : m_q[0].i1;
          m_slot  = (m_idx == 0) ? m_q[0].s0 : m_q[0].s1;
        end
      end
      if (m_acc && m_e.nt != 0) m_q.push_back(m_e);
    end
  end

  // Pulse log used by the hand-computed expectations
  logic [6:0]  p_instr[$];
  logic [1:0]  p_slot[$];
  logic [63:0] p_data[$];
  int          p_lo[$];
  int          hi_run = 0, lo_run = 0, last_hi = 0;
  bit          prev_req = 0;

  always @(negedge clk) begin
    if (rst) begin
      p_instr.delete(); p_slot.delete(); p_data.delete(); p_lo.delete();
      hi_run = 0; lo_run = 0; last_hi = 0; prev_req = 0;
    end else begin
      chk("req_out", req, m_req);
      chk("result_ready", rr, m_q.size() < DEPTH);
      chk("busy", busy, (m_q.size() != 0) || m_req);
      chk("sent_count", scnt, m_sent);
      chk("timeout_err", terr, m_tmo);
      chk("bad_slot_err", berr, m_bad);
      if (m_req) begin
        chk("operand_data", odata, m_data);
        chk("operand_null", onull, m_null);
        chk("dest_instr", oinstr, m_instr);
        chk("dest_slot", oslot, m_slot);
      end
      if (req) begin
        if (!prev_req) begin
          p_instr.push_back(oinstr); p_slot.push_back(oslot);
          p_data.push_back(odata); p_lo.push_back(lo_run);
          hi_run = 0;
        end
        hi_run++;
        lo_run = 0;
      end else begin
        if (prev_req) last_hi = hi_run;
        lo_run++;
      end
      prev_req = req;
    end
  end

  // Network responder: 0 never, 1 immediate, 2 delayed, 3 random, 4 manual
  int ack_mode = 0;
  int age = 0;
  always @(posedge clk) begin
    #1;
    case (ack_mode)
      0: ack = 1'b0;
      1: ack = req;
      2: begin
        if (req) age++; else age = 0;
        ack = req && (age > 2);
      end
      3: ack = ($urandom_range(0, 3) == 0);
      default: ;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] d, input logic a_v, input logic [6:0] a_i, input logic [1:0] a_s,
                       input logic b_v, input logic [6:0] b_i, input logic [1:0] b_s);
    rv = 1'b1; rdata = d; rnull = d[0];
    t0v = a_v; t0i = a_i; t0s = a_s;
    t1v = b_v; t1i = b_i; t1s = b_s;
  endtask

  task automatic enq(input logic [63:0] d, input logic a_v, input logic [6:0] a_i, input logic [1:0] a_s,
                     input logic b_v, input logic [6:0] b_i, input logic [1:0] b_s);
    drive(d, a_v, a_i, a_s, b_v, b_i, b_s);
    tick(1);
    rv = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; rv = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n;
  int n0;

  initial begin
    tick(2);
    rst = 1'b0;
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sent", scnt, 0);
    chk("rst_ready", rr, 1);

    // Single target, ack a few cycles after req
    do_reset();
    ack_mode = 2;
    enq(64'h1234, 1, 7'd5, 2'd1, 0, 7'd0, 2'd0);
    tick(10);
    chk("t1_pulses", p_instr.size(), 1);
    chk("t1_instr", p_instr[0], 5);
    chk("t1_slot", p_slot[0], 1);
    chk("t1_data", p_data[0], 64'h1234);
    chk("t1_sent", scnt, 1);
    chk("t1_busy", busy, 0);

    // Dual target, immediate ack
    do_reset();
    ack_mode = 1;
    enq(64'hABCD, 1, 7'd3, 2'd0, 1, 7'd9, 2'd2);
    tick(10);
    chk("t2_pulses", p_instr.size(), 2);
    chk("t2_first", p_instr[0], 3);
    chk("t2_second", p_instr[1], 9);
    chk("t2_gap", p_lo[1], 1);
    chk("t2_sent", scnt, 2);

    // Full queue with ack held low
    do_reset();
    ack_mode = 0;
    for (int i = 0; i < 4; i++) begin
      drive(64'h100 + 64'(i), 1, 7'(10 + i), 2'd0, 0, 7'd0, 2'd0);
      tick(1);
    end
    chk("t3_full_ready", rr, 0);
    drive(64'h200, 1, 7'd20, 2'd1, 0, 7'd0, 2'd0);
    n = 0;
    while (!rr && n < 100) begin
      tick(1);
      n++;
    end
    chk("t3_full_wait", n, 14);
    tick(1);
    rv = 1'b0;
    tick(90);
    ack_mode = 1;
    tick(20);
    chk("t3_drained", busy, 0);

    // Timeout then next entry proceeds
    do_reset();
    ack_mode = 0;
    enq(64'h77, 1, 7'd7, 2'd0, 0, 7'd0, 2'd0);
    enq(64'h88, 1, 7'd8, 2'd1, 0, 7'd0, 2'd0);
    tick(40);
    chk("t4_pulses", p_instr.size(), 2);
    chk("t4_second", p_instr[1], 8);
    chk("t4_hi_len", last_hi, TIMEOUT);
    chk("t4_terr", terr, 1);
    chk("t4_sent", scnt, 0);

    // Bad slot with no other target
    do_reset();
    enq(64'h55, 1, 7'd4, 2'd3, 0, 7'd0, 2'd0);
    tick(5);
    chk("t5_bad", berr, 1);
    chk("t5_pulses", p_instr.size(), 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", rr, 1);

    // Flush mid-send with concurrent enqueue and ack
    do_reset();
    ack_mode = 1;
    enq(64'h11, 1, 7'd1, 2'd0, 0, 7'd0, 2'd0);
    tick(6);
    chk("t6_sent_pre", scnt, 1);
    ack_mode = 4;
    ack = 1'b0;
    enq(64'h22, 1, 7'd2, 2'd0, 0, 7'd0, 2'd0);
    enq(64'h33, 1, 7'd3, 2'd1, 0, 7'd0, 2'd0);
    tick(2);
    chk("t6_req_pre", req, 1);
    flush = 1'b1;
    ack = 1'b1;
    drive(64'h44, 1, 7'd4, 2'd2, 0, 7'd0, 2'd0);
    tick(1);
    flush = 1'b0; rv = 1'b0; ack = 1'b0;
    chk("t6_req", req, 0);
    chk("t6_busy", busy, 0);
    chk("t6_sent", scnt, 1);
    n0 = p_instr.size();
    tick(10);
    chk("t6_no_more", p_instr.size(), n0);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      ack_mode = ((c % 400) < 60) ? 0 : 3;
      flush = ($urandom_range(0, 49) == 0);
      rv    = $urandom_range(0, 1);
      rdata = {$urandom, $urandom};
      rnull = $urandom_range(0, 1);
      t0v   = $urandom_range(0, 3) != 0;
      t0i   = 7'($urandom);
      t0s   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      t1v   = $urandom_range(0, 1);
      t1i   = 7'($urandom);
      t1s   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      tick(1);
    end
    rv = 1'b0; flush = 1'b0;
    ack_mode = 1;
    tick(50);
    chk("rand_drained", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
